// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection over DEPTH post-decode stages.
// Tracks in-flight destination tags internally and counts stall cycles.
module fwd_hazard_unit #(
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int NOFWD_ADDR = 15,
  parameter int CNT_W      = 16,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_wr_en,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      id_is_load,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  typedef struct packed {
    logic              v;
    logic              ld;
    logic [REG_AW-1:0] dest;
  } tag_t;

  tag_t                    r_tag [1:DEPTH];
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [NUM_SRC*SELW-1:0] w_fwd_sel;
  logic                    w_stall;
  logic [REG_AW-1:0]       w_src;
  logic                    w_hit;

  // Youngest matching stage wins; a load still too young to forward stalls decode.
  // NOTE: combinational logic uses blocking '=' with every output defaulted first,
  // so no latch is inferred; clocked state below uses non-blocking '<=' only.
  always_comb begin
    w_fwd_sel = '0;
    w_stall   = 1'b0;
    w_src     = '0;
    w_hit     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src = id_src[i*REG_AW +: REG_AW];
      w_hit = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!w_hit && id_valid && id_src_used[i] && r_tag[k].v &&
            (r_tag[k].dest == w_src) && (w_src != REG_AW'(NOFWD_ADDR))) begin
          w_hit                     = 1'b1;
          w_fwd_sel[i*SELW +: SELW] = SELW'(k);
          if (r_tag[k].ld && (k <= LOAD_LAT)) begin
            w_stall = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: only the valid bits are reset; ld/dest are don't-care while v=0,
  // so leaving them unreset keeps the payload flops plain enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_tag[k].v <= 1'b0;
      end
      r_stall_cnt <= '0;
    end else begin
      r_tag[1] <= '{v: id_valid & id_wr_en & ~w_stall, ld: id_is_load, dest: id_dest};
      for (int k = 2; k <= DEPTH; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      if (flush) begin
        for (int k = 1; k <= DEPTH; k++) begin
          r_tag[k].v <= 1'b0;
        end
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign fwd_sel   = w_fwd_sel;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random
// stimulus, all checked against an in-flight instruction model.
module tb_fwd_hazard_unit;

  localparam int REG_AW   = 4;
  localparam int NUM_SRC  = 2;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int NOFWD    = 15;
  localparam int CNT_W    = 16;
  localparam int SAT_W    = 4;
  localparam int SELW     = 2;

  logic                      clk = 1'b0;
  logic                      rst, flush, id_valid, id_wr_en, id_is_load;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dest;
  logic [NUM_SRC*SELW-1:0]   fwd_sel, sat_fwd_sel;
  logic                      stall, sat_stall;
  logic [CNT_W-1:0]          stall_cnt;
  logic [SAT_W-1:0]          sat_cnt;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
                    .NOFWD_ADDR(NOFWD), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wr_en(id_wr_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt));

  // Narrow counter copy so saturation is reachable in a short run.
  fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
                    .NOFWD_ADDR(NOFWD), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wr_en(id_wr_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .fwd_sel(sat_fwd_sel), .stall(sat_stall), .stall_cnt(sat_cnt));

  // Model: pipe[s] is the instruction currently in stage s+1.
  typedef struct {
    bit v;
    bit ld;
    int dest;
  } rec_t;

  rec_t pipe [DEPTH];
  int   m_cnt, m_sat;
  int   exp_sel [NUM_SRC];
  bit   exp_stall;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    int src;
    exp_stall = 0;
    for (int op = 0; op < NUM_SRC; op++) begin
      src = int'(id_src[op*REG_AW +: REG_AW]);
      exp_sel[op] = 0;
      if (id_valid && id_src_used[op] && src != NOFWD) begin
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (pipe[s].v && pipe[s].dest == src) exp_sel[op] = s + 1;
        end
      end
      if (exp_sel[op] != 0 && pipe[exp_sel[op]-1].ld && exp_sel[op] <= LOAD_LAT) exp_stall = 1;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      foreach (pipe[s]) pipe[s].v = 0;
      m_cnt = 0;
      m_sat = 0;
    end else begin
      if (exp_stall) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (m_sat < (1 << SAT_W) - 1) m_sat++;
      end
      for (int s = DEPTH - 1; s > 0; s--) pipe[s] = pipe[s-1];
      pipe[0].v    = id_valid && id_wr_en && !exp_stall;
      pipe[0].ld   = id_is_load;
      pipe[0].dest = int'(id_dest);
      if (flush) foreach (pipe[s]) pipe[s].v = 0;
    end
  endtask

  // Compare both instances against the model, then advance one clock.
  task automatic step();
    logic [NUM_SRC*SELW-1:0] sel_vec;
    #1;
    model_eval();
    sel_vec = '0;
    for (int op = 0; op < NUM_SRC; op++) sel_vec[op*SELW +: SELW] = SELW'(exp_sel[op]);
    check("fwd_sel", 32'(fwd_sel), 32'(sel_vec));
    check("stall", 32'(stall), 32'(exp_stall));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("sat_fwd_sel", 32'(sat_fwd_sel), 32'(sel_vec));
    check("sat_stall", 32'(sat_stall), 32'(exp_stall));
    check("sat_cnt", 32'(sat_cnt), 32'(m_sat));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_in(input bit v, input int s0, input int s1, input bit [1:0] used,
                        input bit wr, input int dest, input bit ld, input bit fl);
    rst         = 1'b0;
    flush       = fl;
    id_valid    = v;
    id_src      = {REG_AW'(s1), REG_AW'(s0)};
    id_src_used = used;
    id_wr_en    = wr;
    id_dest     = REG_AW'(dest);
    id_is_load  = ld;
  endtask

  task automatic issue(input int dest, input bit ld);
    set_in(1, 0, 0, 2'b00, 1, dest, ld, 0);
    step();
  endtask

  task automatic flush_idle();
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 1);
    step();
  endtask

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 6));
    return (r == 6) ? NOFWD : r;
  endfunction

  initial begin
    int cnt_before;
    foreach (pipe[s]) pipe[s] = '{v: 0, ld: 0, dest: 0};
    m_cnt = 0;
    m_sat = 0;
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    model_clock();
    #1;
    rst = 1'b1;
    step();
    check("reset_cnt", 32'(stall_cnt), 32'd0);

    // Producers 8, 9, 11 in stages 1..3; src0=3 matches none.
    issue(11, 0); issue(9, 0); issue(8, 0);
    set_in(1, 3, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("nomatch_sel0", 32'(fwd_sel[1:0]), 32'd0);
    check("nomatch_stall", 32'(stall), 32'd0);
    step();
    flush_idle();

    // Match in stage 2, then youngest of three matches wins.
    issue(11, 0); issue(3, 0); issue(8, 0);
    set_in(1, 3, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("stage2_sel0", 32'(fwd_sel[1:0]), 32'd2);
    step();
    issue(3, 0); issue(3, 0); issue(3, 0);
    set_in(1, 3, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("youngest_sel0", 32'(fwd_sel[1:0]), 32'd1);
    step();
    flush_idle();

    // Load-use: one stall cycle, bubble in stage 1, then forward from stage 2.
    issue(3, 1);
    set_in(1, 3, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("lu_stall", 32'(stall), 32'd1);
    cnt_before = m_cnt;
    step();
    check("lu_cnt_inc", 32'(stall_cnt), 32'(cnt_before + 1));
    #1;
    check("lu_sel0_after", 32'(fwd_sel[1:0]), 32'd2);
    check("lu_stall_after", 32'(stall), 32'd0);
    step();
    flush_idle();

    // Young load shadows older non-load; operand 1 forwards from stage 3.
    issue(5, 0); issue(3, 0); issue(3, 1);
    set_in(1, 3, 5, 2'b11, 0, 0, 0, 0);
    #1;
    check("shadow_stall", 32'(stall), 32'd1);
    check("shadow_sel", 32'(fwd_sel), 32'b1101);
    step();
    flush_idle();

    // PC address never forwards; unused operand never stalls.
    issue(15, 1);
    set_in(1, 15, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("pc_sel0", 32'(fwd_sel[1:0]), 32'd0);
    check("pc_stall", 32'(stall), 32'd0);
    step();
    flush_idle();
    issue(3, 1);
    set_in(1, 3, 0, 2'b00, 0, 0, 0, 0);
    #1;
    check("unused_stall", 32'(stall), 32'd0);
    step();
    flush_idle();

    // Flush together with a pending load-use stall.
    issue(3, 1);
    set_in(1, 3, 0, 2'b01, 1, 4, 0, 1);
    #1;
    check("flush_pre_stall", 32'(stall), 32'd1);
    step();
    set_in(1, 3, 0, 2'b01, 0, 0, 0, 0);
    #1;
    check("flush_sel", 32'(fwd_sel), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    step();

    // Self-dependent loads back to back: stall every other cycle, well past 2^SAT_W+3.
    set_in(1, 3, 0, 2'b01, 1, 3, 1, 0);
    repeat (50) step();
    check("sat_hold", 32'(sat_cnt), 32'((1 << SAT_W) - 1));

    // Random traffic with occasional flush and reset.
    repeat (3000) begin
      set_in(($urandom_range(0, 9) != 0), pick_reg(), pick_reg(), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), pick_reg(), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 19) == 0));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined ARM core. Generalises the single-operand forwarding check to NUM_SRC source operands and DEPTH post-decode stages.
- Keeps its own shift register of in-flight destination tags (valid, is_load, dest), so the datapath does not have to supply stage addresses.
- Drives one operand-mux select per source operand, plus a decode stall, and counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 4, register address width.
- NUM_SRC, 2, number of source operands checked per decoded instruction.
- DEPTH, 3, number of tracked stages after decode: stage 1 = EX, 2 = MEM, 3 = WB.
- LOAD_LAT, 1, a load result is not forwardable while the load is in a stage k <= LOAD_LAT. Legal range 0..DEPTH-1.
- NOFWD_ADDR, 15, register address that is never forwarded and never stalls (PC).
- CNT_W, 16, width of the stall counter.
- Local SELW = clog2(DEPTH+1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  invalidates all tracked stages (branch taken).
- id_valid  in  1  decode slot holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source addresses; operand i is at bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  per-operand "operand is read" flag.
- id_wr_en  in  1  decoded instruction writes a register.
- id_dest  in  REG_AW  destination address.
- id_is_load  in  1  decoded instruction is a load.
- fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k = forward from stage k.
- stall  out  1  hold decode and insert a bubble.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: tag[1..DEPTH], each entry = {v, ld, dest}. tag[k] describes the instruction in stage k.
- Reset (rst=1 at a clock edge): all tag.v = 0 and stall_cnt = 0. Result: fwd_sel = 0, stall = 0.
- Shift, every cycle when not in reset:
  - tag[k+1] <= tag[k] for k = 1..DEPTH-1.
  - tag[1] <= {id_valid & id_wr_en & ~stall, id_is_load, id_dest}.
  - While stall=1, a bubble (v=0) enters stage 1 and older stages still advance.
- Flush: all tag.v <= 0 on that edge, overriding the shift. This includes the entry being inserted. If flush and stall are high together, flush wins.
- Match: operand i matches stage k when all of the following hold:
  - id_valid = 1 and id_src_used[i] = 1;
  - tag[k].v = 1;
  - tag[k].dest == src_i;
  - src_i != NOFWD_ADDR.
- fwd_sel (combinational from tags and id inputs):
  - operand i selects the smallest matching k (youngest producer wins);
  - 0 if no stage matches.
- stall (combinational): 1 if, for any operand, the youngest matching stage k has ld = 1 and k <= LOAD_LAT. An older non-load match does not suppress the stall, because its value is stale.
- While stall = 1, fwd_sel still reflects the current match. The datapath ignores fwd_sel during the stall.
- Latency:
  - A decoded producer is visible as stage 1 on the next cycle.
  - With LOAD_LAT = 1, a dependent instruction directly behind a load stalls exactly 1 cycle, then forwards from stage 2.
- Stall with no pipeline advance: if id_* inputs are held and the producer ages out past DEPTH, fwd_sel returns to 0 (register file).
- stall_cnt: increments on each edge where stall = 1 and rst = 0. It saturates at all-ones and does not wrap.
- Reset mid-operation: tags clear immediately at that edge. stall drops the following cycle unless the inputs re-create a hazard, which they cannot with empty tags.

Test Plan:
- Reset, then id_src0 = 3 with producers 8, 9, 11 in stages 1..3, none loads → fwd_sel0 = 0, stall = 0.
- Producers dest 8, 3, 11 (stages 1..3), non-load, src0 = 3 → fwd_sel0 = 2. Then producers 3, 3, 3 → fwd_sel0 = 1 (youngest wins).
- Load with dest = 3 decoded, next instruction src0 = 3, LOAD_LAT = 1:
  - stall = 1 for exactly one cycle and stall_cnt increments by 1;
  - a bubble enters stage 1;
  - the next cycle shows fwd_sel0 = 2, stall = 0.
- Load dest 3 in stage 1 plus non-load dest 3 in stage 2, src0 = 3 → stall = 1. The second operand src1 = 5 matching stage 3 → fwd_sel1 = 3.
- src0 = 15 with a producer dest 15 in stage 1 (a load) → fwd_sel0 = 0, stall = 0. Same case with id_src_used0 = 0 → no stall.
- Flush asserted together with a pending load-use stall → next cycle all fwd_sel = 0, stall = 0. Separately, force 2^CNT_W+3 stall cycles → stall_cnt holds at all-ones.
